ask_frame_sync: RTL and testbench
=================================

# ask_frame_sync

Downstream consumer of the ASK demodulator's recovered bit stream. It hunts for a sync word in the `bit_out`/`bit_valid` stream and then assembles a fixed-length payload into bytes. It checks a trailing XOR checksum and reports frame start, completion, checksum status and inter-bit timeout. It runs in the demodulator's 8.192 MHz `clk` domain, so no clock crossing is needed.

## Interface
- `SYNC_WORD`, default 8'hE4: sync pattern, compared MSB-first.
- `PAYLOAD_BYTES`, default 4: bytes per frame after sync, including the final checksum byte. Legal range 2..15.
- `TIMEOUT_CYC`, default 16384: maximum `clk` cycles between valid bits while in PAYLOAD. Must exceed one bit period at 1 kbps (8192 cycles).
- `clk` in, 1: system clock, same clock as the demodulator.
- `rst` in, 1: asynchronous, active-high reset.
- `en` in, 1: block enable. When low, the block is held in HUNT.
- `bit_in` in, 1: demodulated bit. Connects to the demodulator's `bit_out`.
- `bit_in_valid` in, 1: one-cycle strobe qualifying `bit_in`. Connects to the demodulator's `bit_valid`.
- `byte_out` out, 8: assembled byte, MSB is the first-received bit.
- `byte_valid` out, 1: one-cycle strobe qualifying `byte_out`.
- `frame_start` out, 1: one-cycle pulse on sync detection.
- `frame_done` out, 1: one-cycle pulse when the last payload byte is emitted.
- `frame_ok` out, 1: checksum result. Valid while `frame_done` is high; holds its value until the next `frame_done`.
- `frame_err` out, 1: one-cycle pulse on inter-bit timeout.
- `locked` out, 1: high while in state PAYLOAD.

## Operation
- Shift register `sr[7:0]`: on each `bit_in_valid`, `sr <= {sr[6:0], bit_in}`.
- HUNT:
  - On a valid bit, if `{sr[6:0], bit_in} == SYNC_WORD`: pulse `frame_start`, go to PAYLOAD, clear `sr`, the bit counter (3 bits), the byte counter (4 bits) and the XOR accumulator.
  - Hunting is bit-granular and tolerates overlapping patterns.
- PAYLOAD:
  - On the 8th valid bit of a byte: `byte_out <= {sr[6:0], bit_in}`, pulse `byte_valid`, `acc <= acc ^ byte`, increment the byte counter.
  - When that byte is number `PAYLOAD_BYTES`: pulse `frame_done`, set `frame_ok = ((acc ^ byte) == 8'h00)`, return to HUNT, clear `sr`.
  - Clearing `sr` means payload bits never contribute to the next sync match.
- Timeout:
  - The cycle counter resets on every `bit_in_valid` and on entry to PAYLOAD.
  - If it reaches `TIMEOUT_CYC` in PAYLOAD: pulse `frame_err`, go to HUNT, clear `sr`. No `frame_done` is issued and the partial byte is discarded.
  - The counter does not run in HUNT.
- `en` low: state goes to HUNT and all counters and `sr` clear. `byte_out` and `frame_ok` hold their values. No strobes are issued. If a frame is in progress when `en` drops, it is silently abandoned, with no `frame_err`.
- Arithmetic:
  - The byte counter compares equal to `PAYLOAD_BYTES`.
  - The cycle counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates; no wrap.

## Timing
- Reset values: state HUNT, `sr`=0, all counters 0, `byte_out`=8'h00, and `byte_valid`, `frame_start`, `frame_done`, `frame_ok`, `frame_err`, `locked` all 0.
- Latency:
  - All strobes are registered and assert the cycle after the qualifying `bit_in_valid` edge.
  - `locked` rises in the same cycle as `frame_start`.
  - `locked` falls in the same cycle as `frame_done` or `frame_err`.
- `frame_done` coincides with the last `byte_valid`.
- The block accepts `bit_in_valid` on back-to-back cycles at full rate. No backpressure exists; the consumer must take each `byte_valid` as it occurs.
- Simultaneous events:
  - A `bit_in_valid` in the same cycle the timeout would fire takes priority: the bit is accepted and the counter resets.
  - A valid bit arriving in the cycle the block returns to HUNT is evaluated in HUNT.
- Reset mid-frame: immediate return to the reset values, with no pulses.

## Test plan
- Sync then bytes (default parameters): bits of E4, then 12, 34, 56, 70 (checksum 12^34^56 = 70).
  - Required: `frame_start` pulse, 4 `byte_valid` pulses with 12/34/56/70, `frame_done` with `frame_ok`=1, then `locked`=0.
- Bad checksum: same frame but last byte 71.
  - Required: bytes are emitted, `frame_done` with `frame_ok`=0.
- Offset and false-sync hunt: bits 1,0,1 then E4 then a frame.
  - Required: exactly one `frame_start`, aligned at the end of E4. No byte output before it.
- Timeout: sync, then 13 bits, then no valid bits for 16384 cycles.
  - Required: `frame_err` at that count, `locked`=0, no `frame_done`.
  - Then a new frame: received normally.
- Realistic rate: `bit_in_valid` every 8192 cycles (1 kbps) over a full frame.
  - Required: no timeout, correct bytes.
- Asynchronous `rst` and `en` abort: assert `rst` after the 2nd byte.
  - Required: outputs go to their reset values, with no pulses.
  - Then repeat with `en` low mid-frame; required: no `frame_err`, and the next frame decodes correctly.

Source files
------------

// File: rtl/ask_frame_sync.sv
// ---------------------------------------------------------------------------
// ask_frame_sync
// Frame synchroniser for the ASK demodulator's recovered bit stream.
// Hunts bit-by-bit for SYNC_WORD (MSB first). After a match it assembles
// PAYLOAD_BYTES bytes (the last one is an XOR checksum byte) and reports the
// checksum result. While a frame is in progress, a gap of more than
// TIMEOUT_CYC clk cycles between valid bits aborts the frame.
//
// Ports
//   clk_i           system clock (same domain as the demodulator)
//   rst_i           asynchronous active-high reset
//   en_i            block enable; low holds the block in HUNT
//   bit_in_i        demodulated bit
//   bit_in_valid_i  one-cycle strobe qualifying bit_in_i
//   byte_out_o      assembled byte, MSB = first-received bit
//   byte_valid_o    one-cycle strobe qualifying byte_out_o
//   frame_start_o   one-cycle pulse on sync detection
//   frame_done_o    one-cycle pulse with the last payload byte
//   frame_ok_o      checksum result, updated at frame_done_o and held
//   frame_err_o     one-cycle pulse on inter-bit timeout
//   locked_o        high while a frame payload is being received
// ---------------------------------------------------------------------------
module ask_frame_sync #(
    parameter logic [7:0] SYNC_WORD     = 8'hE4,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         TIMEOUT_CYC   = 16384
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       bit_in_i,
    input  logic       bit_in_valid_i,
    output logic [7:0] byte_out_o,
    output logic       byte_valid_o,
    output logic       frame_start_o,
    output logic       frame_done_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic       locked_o
);

    localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LIM    = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);
    localparam logic [3:0]    LAST_BYTE = 4'(PAYLOAD_BYTES);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t        state_q;
    logic [7:0]    sr_q;
    logic [2:0]    bit_cnt_q;
    logic [3:0]    byte_cnt_q;
    logic [7:0]    acc_q;
    logic [CW-1:0] cyc_cnt_q;
    logic [7:0]    byte_out_q;
    logic          byte_valid_q;
    logic          frame_start_q;
    logic          frame_done_q;
    logic          frame_ok_q;
    logic          frame_err_q;

    logic [7:0]    shift_d;
    logic [3:0]    byte_cnt_d;
    logic [CW-1:0] cyc_cnt_d;

    // Candidate shift value, next byte index and saturating cycle count.
    always_comb begin
        shift_d    = {sr_q[6:0], bit_in_i};
        byte_cnt_d = byte_cnt_q + 4'd1;
        cyc_cnt_d  = (cyc_cnt_q == TO_LIM) ? cyc_cnt_q : (cyc_cnt_q + CYC_ONE);
    end

    // Hunt / payload state machine with registered strobes and data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= HUNT;
            sr_q          <= 8'h00;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 4'd0;
            acc_q         <= 8'h00;
            cyc_cnt_q     <= '0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            if (!en_i) begin
                // Silent abandon: byte_out and frame_ok keep their values.
                state_q    <= HUNT;
                sr_q       <= 8'h00;
                bit_cnt_q  <= 3'd0;
                byte_cnt_q <= 4'd0;
                acc_q      <= 8'h00;
                cyc_cnt_q  <= '0;
            end else begin
                case (state_q)
                    HUNT: begin
                        cyc_cnt_q <= '0;
                        if (bit_in_valid_i) begin
                            if (shift_d == SYNC_WORD) begin
                                frame_start_q <= 1'b1;
                                state_q       <= PAYLOAD;
                                sr_q          <= 8'h00;
                                bit_cnt_q     <= 3'd0;
                                byte_cnt_q    <= 4'd0;
                                acc_q         <= 8'h00;
                            end else begin
                                sr_q <= shift_d;
                            end
                        end
                    end
                    PAYLOAD: begin
                        // A valid bit wins over a timeout in the same cycle.
                        if (bit_in_valid_i) begin
                            cyc_cnt_q <= '0;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            sr_q      <= shift_d;
                            if (bit_cnt_q == 3'd7) begin
                                byte_out_q   <= shift_d;
                                byte_valid_q <= 1'b1;
                                acc_q        <= acc_q ^ shift_d;
                                byte_cnt_q   <= byte_cnt_d;
                                if (byte_cnt_d == LAST_BYTE) begin
                                    // Clearing sr keeps payload bits out of the next hunt.
                                    frame_done_q <= 1'b1;
                                    frame_ok_q   <= ((acc_q ^ shift_d) == 8'h00);
                                    state_q      <= HUNT;
                                    sr_q         <= 8'h00;
                                    bit_cnt_q    <= 3'd0;
                                    byte_cnt_q   <= 4'd0;
                                end
                            end
                        end else if (cyc_cnt_q == TO_LIM) begin
                            frame_err_q <= 1'b1;
                            state_q     <= HUNT;
                            sr_q        <= 8'h00;
                            bit_cnt_q   <= 3'd0;
                            byte_cnt_q  <= 4'd0;
                            cyc_cnt_q   <= '0;
                        end else begin
                            cyc_cnt_q <= cyc_cnt_d;
                        end
                    end
                    default: begin
                        state_q    <= HUNT;
                        sr_q       <= 8'h00;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= 4'd0;
                        cyc_cnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign byte_out_o    = byte_out_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign frame_ok_o    = frame_ok_q;
    assign frame_err_o   = frame_err_q;
    assign locked_o      = (state_q == PAYLOAD);

endmodule

// File: tb/tb_ask_frame_sync.sv
// ---------------------------------------------------------------------------
// Directed bench for ask_frame_sync. A shortened timeout (256 cycles) keeps
// run time small; "realistic rate" frames use a bit period of half the
// timeout, mirroring 8192 vs 16384 cycles in the full-size configuration.
// ---------------------------------------------------------------------------
module tb_ask_frame_sync;

    localparam int TO = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid, frame_start, frame_done, frame_ok, frame_err, locked;

    ask_frame_sync #(
        .SYNC_WORD    (8'hE4),
        .PAYLOAD_BYTES(4),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .bit_in_i      (bit_in),
        .bit_in_valid_i(bit_vld),
        .byte_out_o    (byte_out),
        .byte_valid_o  (byte_valid),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done),
        .frame_ok_o    (frame_ok),
        .frame_err_o   (frame_err),
        .locked_o      (locked)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse counters and captured bytes, sampled on the falling edge.
    int         n_start = 0, n_done = 0, n_err = 0, n_bv = 0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (frame_start) n_start++;
        if (frame_done)  n_done++;
        if (frame_err)   n_err++;
        if (byte_valid) begin
            n_bv++;
            got_q.push_back(byte_out);
        end
    end

    typedef struct {
        string       name;
        logic [31:0] pl;   // four payload bytes, first byte in [31:24]
        int          gap;  // idle cycles between valid bits
        logic        ok;   // expected checksum result
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_start = 0; n_done = 0; n_err = 0; n_bv = 0;
        got_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One valid bit on one clock edge; returns #1 after that edge.
    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_vld = 1'b1;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
        bit_in  = 1'b0;
    endtask

    // MSB-first byte; gap between bits, none after the last bit.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i != 0) idle(gap);
        end
    endtask

    task automatic run_frame(input vec_t v);
        clear_mon();
        send_byte(8'hE4, v.gap);
        chk({v.name, " start"}, {31'd0, frame_start}, 32'd1);
        chk({v.name, " locked"}, {31'd0, locked}, 32'd1);
        idle(v.gap);
        for (int i = 0; i < 3; i++) begin
            send_byte(v.pl[31-8*i -: 8], v.gap);
            idle(v.gap);
        end
        send_byte(v.pl[7:0], v.gap);
        chk({v.name, " done"}, {30'd0, frame_done, byte_valid}, 32'd3);
        chk({v.name, " ok"}, {31'd0, frame_ok}, {31'd0, v.ok});
        chk({v.name, " unlocked"}, {31'd0, locked}, 32'd0);
        idle(3);
        chk({v.name, " n_start"}, n_start, 32'd1);
        chk({v.name, " n_done"}, n_done, 32'd1);
        chk({v.name, " n_err"}, n_err, 32'd0);
        chk({v.name, " n_bytes"}, n_bv, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size())
                chk({v.name, " byte"}, {24'd0, got_q[i]}, {24'd0, v.pl[31-8*i -: 8]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{"basic",    32'h12345670, 0,  1'b1};
        vecs[1] = '{"badsum",   32'h12345671, 0,  1'b0};
        vecs[2] = '{"pattern",  32'hA55AFF00, 0,  1'b1};
        vecs[3] = '{"zeros",    32'h00000000, 0,  1'b1};
        vecs[4] = '{"slowrate", 32'h12345670, TO / 2, 1'b1};
        vecs[5] = '{"edgegap",  32'h01020300, TO, 1'b1};

        // Reset state.
        #1;
        chk("rst byte_out", {24'd0, byte_out}, 32'd0);
        chk("rst flags", {26'd0, byte_valid, frame_start, frame_done, frame_ok, frame_err, locked}, 32'd0);
        idle(3);
        rst = 1'b0;
        idle(2);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Offset / false-sync hunt: 1,0,1 then E4; only the final window matches.
        clear_mon();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 7; i >= 1; i--) begin
            send_bit(k_bit(8'hE4, i));
            chk("hunt early start", {31'd0, frame_start}, 32'd0);
        end
        send_bit(1'b0);
        chk("hunt aligned start", {31'd0, frame_start}, 32'd1);
        chk("hunt no early bytes", n_bv, 32'd0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h70, 0);
        idle(2);
        chk("hunt n_start", n_start, 32'd1);
        chk("hunt ok", {30'd0, frame_ok, locked}, 32'd2);

        // Timeout: sync, 13 bits, silence.
        clear_mon();
        send_byte(8'hE4, 0);
        send_byte(8'hAB, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        k = 0;
        for (int i = 1; i <= TO + 5; i++) begin
            @(posedge clk);
            #1;
            if (frame_err && k == 0) k = i;
        end
        chk("timeout cycle", k, TO + 1);
        chk("timeout unlocked", {31'd0, locked}, 32'd0);
        chk("timeout n_err", n_err, 32'd1);
        chk("timeout n_done", n_done, 32'd0);
        chk("timeout n_bytes", n_bv, 32'd1);
        run_frame(vecs[0]);

        // Asynchronous reset after the second byte.
        clear_mon();
        send_byte(8'hE4, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst byte_out", {24'd0, byte_out}, 32'd0);
        chk("arst flags", {26'd0, byte_valid, frame_start, frame_done, frame_ok, frame_err, locked}, 32'd0);
        n_start = 0; n_done = 0; n_err = 0; n_bv = 0;
        idle(4);
        rst = 1'b0;
        idle(TO + 10);
        chk("arst no pulses", n_start + n_done + n_err + n_bv, 32'd0);
        run_frame(vecs[2]);

        // Enable drop mid-frame: silent abandon, held byte_out/frame_ok.
        clear_mon();
        send_byte(8'hE4, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        en = 1'b0;
        idle(5);
        chk("en locked", {31'd0, locked}, 32'd0);
        chk("en hold", {23'd0, byte_out, frame_ok}, {23'd0, 8'h34, 1'b1});
        en = 1'b1;
        idle(TO + 10);
        chk("en no err", n_err, 32'd0);
        chk("en no done", n_done, 32'd0);
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    function automatic logic k_bit(input logic [7:0] w, input int i);
        return w[i];
    endfunction

endmodule
